// File: rtl/slot_arbiter_if.sv
// Bus bundle for slot_arbiter. The master side drives mode/req. The slave side returns
// the registered grant, the TDM slot and the FSM state and hold count for observation.
interface slot_arbiter_if #(
  parameter int N_CH  = 8,
  parameter int IDX_W = 3
);
  logic             mode;
  logic [N_CH-1:0]  req;
  logic [N_CH-1:0]  gnt;
  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] slot;
  logic             state;
  logic [7:0]       hold_cnt;

  modport master (
    output mode, req,
    input  gnt, gnt_valid, gnt_idx, slot, state, hold_cnt
  );

  modport slave (
    input  mode, req,
    output gnt, gnt_valid, gnt_idx, slot, state, hold_cnt
  );
endinterface

// File: rtl/slot_arbiter.sv
// Slot arbiter: fixed TDM slots (mode 0) or work-conserving round-robin with a per-owner hold
// limit (mode 1). The grant is registered and one-hot, or all-zero.
module slot_arbiter #(
  parameter int N_CH     = 8,
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 4
) (
  input logic          clk,
  input logic          rst,
  slot_arbiter_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [IDX_W-1:0] LAST      = IDX_W'(N_CH - 1);
  localparam logic [7:0]       HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] slot_q, slot_d, ptr_q, ptr_d, idx_q, idx_d;
  logic [IDX_W-1:0] start, pick, k;
  logic [N_CH-1:0]  gnt_q, gnt_d;
  logic [7:0]       hold_q, hold_d;
  logic             mode_q, found;

  function automatic logic [IDX_W-1:0] inc(input logic [IDX_W-1:0] v);
    return (v == LAST) ? '0 : v + 1'b1;
  endfunction

  // The search runs from ptr when idle, or from owner+1 when the current owner releases.
  // The owner is visited last, so on a timeout it is picked again only when no other request is pending.
  always_comb begin
    start = (state_q == IDLE) ? ptr_q : inc(idx_q);
    found = 1'b0;
    pick  = start;
    k     = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      k = IDX_W'((int'(start) + i) % N_CH);
      if (bus.req[k]) begin
        found = 1'b1;
        pick  = k;
      end
    end
  end

  always_comb begin
    slot_d  = inc(slot_q);
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    hold_d  = hold_q;
    if (bus.mode != mode_q) begin
      gnt_d   = '0;
      state_d = IDLE;
      hold_d  = '0;
    end else if (!mode_q) begin
      gnt_d = '0;
      if (bus.req[slot_q]) begin
        gnt_d[slot_q] = 1'b1;
        idx_d         = slot_q;
      end
    end else begin
      case (state_q)
        IDLE: begin
          gnt_d = '0;
          if (found) begin
            gnt_d[pick] = 1'b1;
            idx_d       = pick;
            ptr_d       = inc(pick);
            hold_d      = '0;
            state_d     = GRANT;
          end
        end
        GRANT: begin
          if (bus.req[idx_q] && (hold_q < HOLD_LAST)) begin
            hold_d = hold_q + 8'd1;
          end else if (found) begin
            gnt_d       = '0;
            gnt_d[pick] = 1'b1;
            idx_d       = pick;
            ptr_d       = inc(pick);
            hold_d      = '0;
          end else begin
            gnt_d   = '0;
            hold_d  = '0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      slot_q  <= '0;
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
      hold_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      hold_q  <= hold_d;
      mode_q  <= bus.mode;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = |gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.slot      = slot_q;
  assign bus.state     = state_q;
  assign bus.hold_cnt  = hold_q;
endmodule

// File: tb/tb_slot_arbiter.sv
// Directed bench for slot_arbiter (N_CH=8, MAX_HOLD=4). It exercises TDM walking, round-robin hold and
// rotation, owner drop, and reset and mode change in the middle of a grant.
module tb_slot_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  slot_arbiter_if #(.N_CH(8), .IDX_W(3)) bus ();

  slot_arbiter #(.N_CH(8), .IDX_W(3), .MAX_HOLD(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests  = 0;
  int n_fail   = 0;
  int exp_slot = 0;
  int exp_idx  = 0;

  // Advance one edge; the slot model follows the reset level seen at that edge.
  task automatic tick();
    logic r;
    r = rst;
    @(posedge clk);
    #1;
    exp_slot = r ? (exp_slot + 1) % 8 : 0;
  endtask

  task automatic test_reset();
    bus.mode = 1'b0;
    bus.req  = 8'h00;
    rst      = 1'b0;
    tick(); tick(); tick();
    n_tests++; if (bus.gnt !== 8'h00) begin n_fail++; $display("FAIL reset gnt: got %h want 00", bus.gnt); end
    n_tests++; if (bus.gnt_valid !== 1'b0) begin n_fail++; $display("FAIL reset gnt_valid: got %b want 0", bus.gnt_valid); end
    n_tests++; if (bus.gnt_idx !== 3'd0) begin n_fail++; $display("FAIL reset gnt_idx: got %0d want 0", bus.gnt_idx); end
    n_tests++; if (bus.slot !== 3'd0) begin n_fail++; $display("FAIL reset slot: got %0d want 0", bus.slot); end
    n_tests++; if (bus.state !== 1'b0) begin n_fail++; $display("FAIL reset state: got %b want 0", bus.state); end
    n_tests++; if (bus.hold_cnt !== 8'd0) begin n_fail++; $display("FAIL reset hold_cnt: got %0d want 0", bus.hold_cnt); end
    rst = 1'b1;
  endtask

  task automatic test_tdm_all();
    bus.req = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      logic [7:0] eg;
      eg      = 8'h01 << exp_slot;
      exp_idx = exp_slot;
      tick();
      n_tests++; if (bus.gnt !== eg) begin n_fail++; $display("FAIL tdm_all gnt cyc %0d: got %h want %h", i, bus.gnt, eg); end
      n_tests++; if (bus.gnt_idx !== 3'(exp_idx)) begin n_fail++; $display("FAIL tdm_all gnt_idx cyc %0d: got %0d want %0d", i, bus.gnt_idx, exp_idx); end
      n_tests++; if (bus.slot !== 3'(exp_slot)) begin n_fail++; $display("FAIL tdm_all slot cyc %0d: got %0d want %0d", i, bus.slot, exp_slot); end
      n_tests++; if (bus.gnt_valid !== 1'b1) begin n_fail++; $display("FAIL tdm_all gnt_valid cyc %0d: got %b want 1", i, bus.gnt_valid); end
    end
  endtask

  task automatic test_tdm_single();
    bus.req = 8'h04;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] eg;
      eg = (exp_slot == 2) ? 8'h04 : 8'h00;
      if (exp_slot == 2) exp_idx = 2;
      tick();
      n_tests++; if (bus.gnt !== eg) begin n_fail++; $display("FAIL tdm_single gnt cyc %0d: got %h want %h", i, bus.gnt, eg); end
      n_tests++; if (bus.gnt_idx !== 3'(exp_idx)) begin n_fail++; $display("FAIL tdm_single gnt_idx cyc %0d: got %0d want %0d", i, bus.gnt_idx, exp_idx); end
      n_tests++; if (bus.gnt_valid !== (eg != 8'h00)) begin n_fail++; $display("FAIL tdm_single gnt_valid cyc %0d: got %b want %b", i, bus.gnt_valid, eg != 8'h00); end
    end
  endtask

  task automatic test_rr_hold();
    logic [7:0] gt [9];
    logic [7:0] ht [9];
    gt = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h80, 8'h80, 8'h80, 8'h80, 8'h01};
    ht = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
    bus.mode = 1'b1;
    bus.req  = 8'h81;
    tick();
    n_tests++; if (bus.gnt !== 8'h00) begin n_fail++; $display("FAIL rr_hold mode switch gnt: got %h want 00", bus.gnt); end
    n_tests++; if (bus.state !== 1'b0) begin n_fail++; $display("FAIL rr_hold mode switch state: got %b want 0", bus.state); end
    for (int i = 0; i < 9; i++) begin
      tick();
      n_tests++; if (bus.gnt !== gt[i]) begin n_fail++; $display("FAIL rr_hold gnt cyc %0d: got %h want %h", i, bus.gnt, gt[i]); end
      n_tests++; if (bus.hold_cnt !== ht[i]) begin n_fail++; $display("FAIL rr_hold hold_cnt cyc %0d: got %0d want %0d", i, bus.hold_cnt, ht[i]); end
      n_tests++; if (bus.state !== 1'b1) begin n_fail++; $display("FAIL rr_hold state cyc %0d: got %b want 1", i, bus.state); end
    end
  endtask

  task automatic test_rr_single();
    bus.req = 8'h08;
    for (int i = 0; i < 9; i++) begin
      tick();
      n_tests++; if (bus.gnt !== 8'h08) begin n_fail++; $display("FAIL rr_single gnt cyc %0d: got %h want 08", i, bus.gnt); end
      n_tests++; if (bus.hold_cnt !== 8'(i % 4)) begin n_fail++; $display("FAIL rr_single hold_cnt cyc %0d: got %0d want %0d", i, bus.hold_cnt, i % 4); end
      n_tests++; if (bus.gnt_idx !== 3'd3) begin n_fail++; $display("FAIL rr_single gnt_idx cyc %0d: got %0d want 3", i, bus.gnt_idx); end
    end
  endtask

  task automatic test_owner_drop();
    bus.req = 8'h28;
    tick();
    n_tests++; if (bus.gnt !== 8'h08) begin n_fail++; $display("FAIL drop hold gnt: got %h want 08", bus.gnt); end
    bus.req = 8'h20;
    tick();
    n_tests++; if (bus.gnt !== 8'h20) begin n_fail++; $display("FAIL drop handoff gnt: got %h want 20", bus.gnt); end
    n_tests++; if (bus.gnt_idx !== 3'd5) begin n_fail++; $display("FAIL drop handoff gnt_idx: got %0d want 5", bus.gnt_idx); end
    bus.req = 8'h08;
    tick();
    n_tests++; if (bus.gnt !== 8'h08) begin n_fail++; $display("FAIL drop back gnt: got %h want 08", bus.gnt); end
    bus.req = 8'h00;
    tick();
    n_tests++; if (bus.gnt !== 8'h00) begin n_fail++; $display("FAIL drop idle gnt: got %h want 00", bus.gnt); end
    n_tests++; if (bus.gnt_valid !== 1'b0) begin n_fail++; $display("FAIL drop idle gnt_valid: got %b want 0", bus.gnt_valid); end
    n_tests++; if (bus.gnt_idx !== 3'd3) begin n_fail++; $display("FAIL drop idle gnt_idx hold: got %0d want 3", bus.gnt_idx); end
    n_tests++; if (bus.state !== 1'b0) begin n_fail++; $display("FAIL drop idle state: got %b want 0", bus.state); end
    tick();
    n_tests++; if (bus.gnt !== 8'h00) begin n_fail++; $display("FAIL drop stay idle gnt: got %h want 00", bus.gnt); end
  endtask

  task automatic test_mode_toggle();
    bus.req = 8'h08;
    tick();
    n_tests++; if (bus.gnt !== 8'h08) begin n_fail++; $display("FAIL toggle pre gnt: got %h want 08", bus.gnt); end
    tick();
    n_tests++; if (bus.hold_cnt !== 8'd1) begin n_fail++; $display("FAIL toggle pre hold_cnt: got %0d want 1", bus.hold_cnt); end
    bus.mode = 1'b0;
    tick();
    n_tests++; if (bus.gnt !== 8'h00) begin n_fail++; $display("FAIL toggle gnt: got %h want 00", bus.gnt); end
    n_tests++; if (bus.hold_cnt !== 8'd0) begin n_fail++; $display("FAIL toggle hold_cnt: got %0d want 0", bus.hold_cnt); end
    n_tests++; if (bus.slot !== 3'(exp_slot)) begin n_fail++; $display("FAIL toggle slot: got %0d want %0d", bus.slot, exp_slot); end
    exp_idx = 3;
    for (int i = 0; i < 9; i++) begin
      logic [7:0] eg;
      eg = (exp_slot == 3) ? 8'h08 : 8'h00;
      tick();
      n_tests++; if (bus.gnt !== eg) begin n_fail++; $display("FAIL toggle tdm gnt cyc %0d: got %h want %h", i, bus.gnt, eg); end
      n_tests++; if (bus.slot !== 3'(exp_slot)) begin n_fail++; $display("FAIL toggle tdm slot cyc %0d: got %0d want %0d", i, bus.slot, exp_slot); end
      n_tests++; if (bus.gnt_idx !== 3'(exp_idx)) begin n_fail++; $display("FAIL toggle tdm gnt_idx cyc %0d: got %0d want %0d", i, bus.gnt_idx, exp_idx); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] eg;
    bus.req = 8'hFF;
    eg = 8'h01 << exp_slot;
    tick();
    n_tests++; if (bus.gnt !== eg) begin n_fail++; $display("FAIL rst_mid pre gnt: got %h want %h", bus.gnt, eg); end
    rst = 1'b0;
    tick();
    n_tests++; if (bus.gnt !== 8'h00) begin n_fail++; $display("FAIL rst_mid gnt: got %h want 00", bus.gnt); end
    n_tests++; if (bus.slot !== 3'd0) begin n_fail++; $display("FAIL rst_mid slot: got %0d want 0", bus.slot); end
    n_tests++; if (bus.gnt_idx !== 3'd0) begin n_fail++; $display("FAIL rst_mid gnt_idx: got %0d want 0", bus.gnt_idx); end
    rst      = 1'b1;
    bus.mode = 1'b1;
    tick();
    n_tests++; if (bus.gnt !== 8'h00) begin n_fail++; $display("FAIL rst_mode1 first gnt: got %h want 00", bus.gnt); end
    n_tests++; if (bus.slot !== 3'd1) begin n_fail++; $display("FAIL rst_mode1 slot: got %0d want 1", bus.slot); end
    tick();
    n_tests++; if (bus.gnt !== 8'h01) begin n_fail++; $display("FAIL rst_mode1 grant gnt: got %h want 01", bus.gnt); end
    n_tests++; if (bus.gnt_idx !== 3'd0) begin n_fail++; $display("FAIL rst_mode1 gnt_idx: got %0d want 0", bus.gnt_idx); end
    tick();
    n_tests++; if (bus.hold_cnt !== 8'd1) begin n_fail++; $display("FAIL rst_mode1 hold_cnt: got %0d want 1", bus.hold_cnt); end
  endtask

  initial begin
    test_reset();
    test_tdm_all();
    test_tdm_single();
    test_rr_hold();
    test_rr_single();
    test_owner_drop();
    test_mode_toggle();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
